// File: rtl/uart_acc_pkg.sv
// Shared types and constants for the UART frame accumulator.
// The escape constants are only used when UART_ACC_ESCAPE_EN is defined.
package uart_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_TERM2 = 2'd2,
        ST_HOLD  = 2'd3
    } acc_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_BADTERM  = 2'd3;

    localparam logic [7:0] ESC_BYTE = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;

endpackage

// File: rtl/uart_acc_timeout.sv
// Inter-byte watchdog. Counts enabled cycles since the last clear and
// flags expiry in the LIMIT-th enabled cycle, so a gap of exactly LIMIT
// cycles between accepts expires in the same cycle the next accept lands
// (the parent gives the accept priority). Clears whenever it is disabled.
module uart_acc_timeout #(
    parameter int LIMIT = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter only has to hold 0 .. LIMIT-1.
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && !clear && (count_q == CNT_W'(LIMIT - 1));

    // Next count: zero when cleared or idle, hold once expired.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (!expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_accumulator.sv
// UART frame accumulator: gathers strobed bytes into a frame buffer, ends
// the frame on a per-frame selectable terminator (CR, or BE EF pair), and
// presents it through a valid/ready handshake. Errors are sticky until the
// next frame starts. Optional byte escaping plus a dropped-byte counter are
// enabled with the UART_ACC_ESCAPE_EN macro.
module uart_frame_accumulator
    import uart_acc_pkg::*;
#(
    parameter int         MAX_BYTES = 128,
    parameter int         SIZE_W    = 8,
    parameter int         TIMEOUT   = 2000,
    parameter logic [7:0] TERM_CR   = 8'h0D,
    parameter logic [7:0] TERM_HI   = 8'hBE,
    parameter logic [7:0] TERM_LO   = 8'hEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_reset,
    input  logic [7:0]             input_data,
    input  logic                   accumulate,
    input  logic                   ble_side,
    output logic [8*MAX_BYTES-1:0] output_data,
    output logic [SIZE_W-1:0]      output_data_size,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
`ifdef UART_ACC_ESCAPE_EN
    ,
    output logic [7:0]             drop_count
`endif
);

    acc_state_t             state_q, state_d;
    logic                   acc_dly_q, acc_dly_d;
    logic                   mode_q, mode_d;
    logic [SIZE_W-1:0]      count_q, count_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic                   error_q, error_d;
    logic [1:0]             code_q, code_d;
    logic [8*MAX_BYTES-1:0] out_q, out_d;
    logic [8*MAX_BYTES-1:0] buf_flat;

    logic       accept;
    logic       mode_eff;
    logic       do_store, do_hold, do_abort;
    logic       store_en, clear_buf;
    logic [7:0] store_byte;
    logic       tmo_enable, tmo_expired;

`ifdef UART_ACC_ESCAPE_EN
    logic       esc_q, esc_d;
    logic [7:0] drop_q, drop_d;
`endif

    // One byte per rising edge of the strobe level, seen in the clk domain.
    assign accept = accumulate && !acc_dly_q;

    assign tmo_enable = (state_q == ST_ACCUM) || (state_q == ST_TERM2);

    uart_acc_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Frame control: classify each accepted byte, then apply store/hold/abort.
    always_comb begin
        state_d    = state_q;
        acc_dly_d  = accumulate;
        mode_d     = mode_q;
        count_d    = count_q;
        size_d     = size_q;
        error_d    = error_q;
        code_d     = code_q;
        out_d      = out_q;
        do_store   = 1'b0;
        do_hold    = 1'b0;
        do_abort   = 1'b0;
        store_en   = 1'b0;
        clear_buf  = 1'b0;
        store_byte = input_data;
`ifdef UART_ACC_ESCAPE_EN
        esc_d      = esc_q;
`endif
        // The first byte of a frame uses the live mode input; later bytes
        // use the mode latched when the frame started.
        mode_eff   = (state_q == ST_IDLE) ? ble_side : mode_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if ((state_q == ST_ACCUM) && soft_reset) begin
                    do_abort = 1'b1;
                end else if (accept) begin
                    if (state_q == ST_IDLE) begin
                        mode_d  = ble_side;
                        error_d = 1'b0;
                        code_d  = ERR_NONE;
                    end
                    state_d = ST_ACCUM;
`ifdef UART_ACC_ESCAPE_EN
                    // An escaped byte is always data, never a terminator.
                    if (esc_q) begin
                        do_store   = 1'b1;
                        store_byte = input_data ^ ESC_XOR;
                        esc_d      = 1'b0;
                    end else if (input_data == ESC_BYTE) begin
                        esc_d = 1'b1;
                    end else
`endif
                    if (mode_eff && (input_data == TERM_CR)) begin
                        do_hold = 1'b1;
                    end else if (!mode_eff && (input_data == TERM_HI)) begin
                        state_d = ST_TERM2;
                    end else begin
                        do_store = 1'b1;
                    end
                end else if (tmo_expired) begin
                    do_abort = 1'b1;
                    error_d  = 1'b1;
                    code_d   = ERR_TIMEOUT;
                end
            end
            ST_TERM2: begin
                if (soft_reset) begin
                    do_abort = 1'b1;
                end else if (accept) begin
                    if (input_data == TERM_LO) begin
                        do_hold = 1'b1;
                    end else begin
                        do_abort = 1'b1;
                        error_d  = 1'b1;
                        code_d   = ERR_BADTERM;
                    end
                end else if (tmo_expired) begin
                    do_abort = 1'b1;
                    error_d  = 1'b1;
                    code_d   = ERR_TIMEOUT;
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full buffer turns the next data byte into an overflow abort.
        if (do_store) begin
            if (count_q == SIZE_W'(MAX_BYTES)) begin
                do_abort = 1'b1;
                error_d  = 1'b1;
                code_d   = ERR_OVERFLOW;
            end else begin
                store_en = 1'b1;
                count_d  = count_q + SIZE_W'(1);
            end
        end

        if (do_hold) begin
            state_d   = ST_HOLD;
            out_d     = buf_flat;
            size_d    = count_q;
            clear_buf = 1'b1;
            count_d   = '0;
        end

        if (do_abort) begin
            state_d   = ST_IDLE;
            clear_buf = 1'b1;
            count_d   = '0;
        end

`ifdef UART_ACC_ESCAPE_EN
        if (do_hold || do_abort) begin
            esc_d = 1'b0;
        end
`endif
    end

    // Frame buffer: one byte lane per slot, written at the current count.
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_buf
        logic [7:0] byte_q, byte_d;

        // Byte lane update: clear on frame hand-off/abort, else store.
        always_comb begin
            byte_d = byte_q;
            if (clear_buf) begin
                byte_d = '0;
            end else if (store_en && (count_q == SIZE_W'(gi))) begin
                byte_d = store_byte;
            end
        end

        // Byte lane register.
        always_ff @(posedge clk) begin
            if (reset) begin
                byte_q <= '0;
            end else begin
                byte_q <= byte_d;
            end
        end

        assign buf_flat[8*gi +: 8] = byte_q;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_dly_q <= 1'b0;
            mode_q    <= 1'b0;
            count_q   <= '0;
            size_q    <= '0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_dly_q <= acc_dly_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            size_q    <= size_d;
            error_q   <= error_d;
            code_q    <= code_d;
            out_q     <= out_d;
        end
    end

`ifdef UART_ACC_ESCAPE_EN
    // Dropped-byte count: saturating, bumped on every accept while holding.
    always_comb begin
        drop_d = drop_q;
        if ((state_q == ST_HOLD) && accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Escape and drop counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            esc_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            esc_q  <= esc_d;
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

    assign output_data      = out_q;
    assign output_data_size = size_q;
    assign frame_valid      = (state_q == ST_HOLD);
    assign done             = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign error            = error_q;
    assign error_code       = code_q;

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Directed bench for uart_frame_accumulator (MAX_BYTES=4, TIMEOUT=20).
// Expected frames go into a queue as stimulus is driven; a negedge monitor
// pops and compares each frame on its valid/ready handshake.
module tb_uart_frame_accumulator;

    localparam int MAX_BYTES = 4;
    localparam int SIZE_W    = 8;
    localparam int TIMEOUT   = 20;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   soft_reset;
    logic [7:0]             input_data;
    logic                   accumulate;
    logic                   ble_side;
    logic [8*MAX_BYTES-1:0] output_data;
    logic [SIZE_W-1:0]      output_data_size;
    logic                   frame_valid;
    logic                   frame_ready;
    logic                   done;
    logic                   error;
    logic [1:0]             error_code;
`ifdef UART_ACC_ESCAPE_EN
    logic [7:0]             drop_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  size;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    uart_frame_accumulator #(
        .MAX_BYTES (MAX_BYTES),
        .SIZE_W    (SIZE_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .soft_reset       (soft_reset),
        .input_data       (input_data),
        .accumulate       (accumulate),
        .ble_side         (ble_side),
        .output_data      (output_data),
        .output_data_size (output_data_size),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .done             (done),
        .error            (error),
        .error_code       (error_code)
`ifdef UART_ACC_ESCAPE_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe one byte: accepted on the first edge, strobe low by the second.
    task automatic send_byte(input logic [7:0] b);
        input_data = b;
        accumulate = 1'b1;
        tick(1);
        accumulate = 1'b0;
        tick(1);
    endtask

    task automatic push_frame(input logic [31:0] data, input logic [7:0] size);
        frame_t f;
        f.data = data;
        f.size = size;
        exp_q.push_back(f);
        $display("expect frame data=0x%08h size=%0d", data, size);
    endtask

    // Scoreboard: compare each handed-off frame with the oldest expectation.
    always @(negedge clk) begin : monitor
        frame_t e;
        if (!reset && frame_valid && frame_ready) begin
            check("frame_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("frame out data=0x%08h size=%0d", output_data, output_data_size);
                check("frame_data", 64'(output_data), 64'(e.data));
                check("frame_size", 64'(output_data_size), 64'(e.size));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        soft_reset  = 1'b0;
        accumulate  = 1'b0;
        ble_side    = 1'b0;
        frame_ready = 1'b1;
        input_data  = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_done",  64'(done), 64'd1);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_code",  64'(error_code), 64'd0);
        check("rst_size",  64'(output_data_size), 64'd0);
        check("rst_data",  64'(output_data), 64'd0);

        // CR-terminated frame, latency of the terminator.
        ble_side = 1'b1;
        send_byte(8'h41);
        check("t1_done_busy", 64'(done), 64'd0);
        send_byte(8'h42);
        send_byte(8'h43);
        push_frame(32'h0043_4241, 8'd3);
        check("t1_valid_before", 64'(frame_valid), 64'd0);
        input_data = 8'h0D;
        accumulate = 1'b1;
        tick(1);
        check("t1_valid_latency", 64'(frame_valid), 64'd1);
        check("t1_done_hold", 64'(done), 64'd1);
        check("t1_error", 64'(error), 64'd0);
        accumulate = 1'b0;
        tick(1);
        check("t1_released", 64'(frame_valid), 64'd0);

        // Two-byte terminator; mode is latched at frame start.
        ble_side = 1'b0;
        push_frame(32'h0000_0001, 8'd1);
        send_byte(8'h01);
        ble_side = 1'b1;
        send_byte(8'hBE);
        send_byte(8'hEF);
        ble_side = 1'b0;
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'h00);
        check("t2_badterm_error", 64'(error), 64'd1);
        check("t2_badterm_code",  64'(error_code), 64'd3);
        check("t2_badterm_valid", 64'(frame_valid), 64'd0);
        check("t2_badterm_done",  64'(done), 64'd1);

        // Timeout fires exactly TIMEOUT cycles after the last accept.
        ble_side = 1'b1;
        send_byte(8'h55);
        tick(18);
        check("t3_pre_timeout_error", 64'(error), 64'd0);
        check("t3_pre_timeout_done",  64'(done), 64'd0);
        tick(1);
        check("t3_timeout_error", 64'(error), 64'd1);
        check("t3_timeout_code",  64'(error_code), 64'd1);
        check("t3_timeout_done",  64'(done), 64'd1);

        // Gaps of 19 (and one of 20, where the accept wins) stay clean;
        // four data bytes is also the largest frame that fits.
        push_frame(32'h4433_2211, 8'd4);
        send_byte(8'h11);
        tick(17);
        send_byte(8'h22);
        tick(17);
        send_byte(8'h33);
        tick(18);
        send_byte(8'h44);
        tick(17);
        check("t3_gap_error", 64'(error), 64'd0);
        check("t3_gap_done",  64'(done), 64'd0);
        send_byte(8'h0D);
        check("t3_gap_frame_error", 64'(error), 64'd0);

        // Overflow on the fifth data byte.
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        check("t4_full_error", 64'(error), 64'd0);
        send_byte(8'hA5);
        check("t4_ovf_error", 64'(error), 64'd1);
        check("t4_ovf_code",  64'(error_code), 64'd2);
        check("t4_ovf_done",  64'(done), 64'd1);
        check("t4_ovf_valid", 64'(frame_valid), 64'd0);

        // soft_reset aborts without error; next frame is a zero-length one.
        send_byte(8'h12);
        check("t5_busy", 64'(done), 64'd0);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("t5_soft_done",  64'(done), 64'd1);
        check("t5_soft_error", 64'(error), 64'd0);
        push_frame(32'h0000_0000, 8'd0);
        send_byte(8'h0D);

        // Backpressure: held frame survives extra strobes and soft_reset.
        frame_ready = 1'b0;
        push_frame(32'h0000_6261, 8'd2);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h0D);
        check("t6_valid", 64'(frame_valid), 64'd1);
        send_byte(8'h99);
        send_byte(8'h0D);
        send_byte(8'h77);
        check("t6_hold_valid", 64'(frame_valid), 64'd1);
        check("t6_hold_data",  64'(output_data), 64'h6261);
        check("t6_hold_size",  64'(output_data_size), 64'd2);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("t6_soft_hold", 64'(frame_valid), 64'd1);
`ifdef UART_ACC_ESCAPE_EN
        check("t6_drop_count", 64'(drop_count), 64'd3);
`endif
        frame_ready = 1'b1;
        tick(1);
        check("t6_released", 64'(frame_valid), 64'd0);

        // Escape byte handling (or plain data without the feature).
        ble_side = 1'b1;
`ifdef UART_ACC_ESCAPE_EN
        push_frame(32'h0000_000D, 8'd1);
        send_byte(8'h7D);
        send_byte(8'h2D);
        send_byte(8'h0D);
`else
        push_frame(32'h0000_007D, 8'd1);
        send_byte(8'h7D);
        send_byte(8'h0D);
`endif
        check("t7_error", 64'(error), 64'd0);

        // Hard reset in the middle of a frame.
        send_byte(8'h41);
        check("t8_busy", 64'(done), 64'd0);
        reset = 1'b1;
        tick(1);
        check("t8_rst_done",  64'(done), 64'd1);
        check("t8_rst_valid", 64'(frame_valid), 64'd0);
        check("t8_rst_error", 64'(error), 64'd0);
        check("t8_rst_code",  64'(error_code), 64'd0);
        check("t8_rst_size",  64'(output_data_size), 64'd0);
        check("t8_rst_data",  64'(output_data), 64'd0);
`ifdef UART_ACC_ESCAPE_EN
        check("t8_rst_drop",  64'(drop_count), 64'd0);
`endif
        reset = 1'b0;
        tick(2);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_accumulator.md
Name: uart_frame_accumulator

Overview:
Parametrised successor of the UART command accumulator. It collects bytes from a UART receiver or the BLE bridge into one frame register, detects an end-of-frame terminator (selectable per frame), and presents the frame with a valid/ready handshake. It adds fully synchronous edge detection, sized buffering, error codes and backpressure. It sits between the UART RX byte path and the command decoder.

Parameters:
MAX_BYTES, 128, frame buffer depth in bytes (1..255).
SIZE_W, 8, width of output_data_size; must satisfy 2**SIZE_W > MAX_BYTES.
TIMEOUT, 2000, maximum clk cycles allowed between accepted bytes inside a frame.
TERM_CR, 8'h0D, single-byte terminator used in mode 1.
TERM_HI, 8'hBE, first byte of the two-byte terminator used in mode 0.
TERM_LO, 8'hEF, second byte of the two-byte terminator used in mode 0.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
soft_reset  in  1  synchronous abort of the current frame; does not clear a pending frame.
input_data  in  8  byte from the receiver; sampled on the accept cycle.
accumulate  in  1  byte strobe level; a rising edge (sampled on clk) is one byte.
ble_side  in  1  terminator mode, latched at frame start: 1 = TERM_CR, 0 = TERM_HI,TERM_LO.
output_data  out  8*MAX_BYTES  frame payload; byte k is at bits [8k+7:8k], unused bytes are 0.
output_data_size  out  SIZE_W  payload byte count, excluding terminator bytes.
frame_valid  out  1  frame available; output_data and output_data_size are stable while high.
frame_ready  in  1  consumer accepts the frame when frame_valid && frame_ready.
done  out  1  high when no frame is in progress.
error  out  1  sticky error flag.
error_code  out  2  0 none, 1 timeout, 2 overflow, 3 bad terminator.

Behaviour:
- Reset: outputs 0 except done=1; state IDLE; acc_d=0.
- Accept event: accept = accumulate && !acc_d, where acc_d is a registered copy of accumulate. No asynchronous logic and no flag-clear pulses.
- States: IDLE, ACCUM, TERM2, HOLD.
- IDLE, on accept:
  - Latch the mode from ble_side.
  - Clear error and error_code; drive done=0.
  - Process the byte as in ACCUM. A terminator as the first byte produces a zero-length frame.
- ACCUM, on accept:
  - Terminator in mode 1 -> HOLD.
  - TERM_HI in mode 0 -> TERM2.
  - Otherwise store the byte at index count and increment count.
  - If count == MAX_BYTES before storing: error_code=2, error=1, discard the frame, go to IDLE.
- TERM2, on accept:
  - Byte == TERM_LO -> HOLD.
  - Any other byte -> error_code=3, error=1, go to IDLE.
  - TERM_HI is never stored.
- HOLD entry (same cycle):
  - output_data <= buffer; output_data_size <= count.
  - frame_valid=1, done=1.
  - Clear the buffer and count.
- HOLD exit: frame_valid && frame_ready -> frame_valid=0, go to IDLE next cycle.
- Backpressure: accepts arriving in HOLD are dropped (see Optional Feature). The frame register is never overwritten while frame_valid=1.
- Timeout:
  - Counter runs in ACCUM and TERM2 only; it zeroes on each accept and in IDLE/HOLD.
  - When the count reaches TIMEOUT: error_code=1, error=1, discard the frame, go to IDLE.
  - If an accept and the timeout occur in the same cycle, the accept wins.
- soft_reset:
  - In ACCUM or TERM2: discard the frame, go to IDLE, done=1.
  - In HOLD: no effect on the pending frame.
  - Never sets error.
- reset mid-frame: everything returns to reset values, including a pending frame.
- Latency: frame_valid rises one clk after the accept cycle of the final terminator byte.

Optional Feature:
UART_ACC_ESCAPE_EN
- With the macro:
  - Byte 8'h7D is an escape. The next accepted byte X is stored as X^8'h20 and never treated as a terminator.
  - A terminator, timeout or soft_reset while an escape is pending follows the normal rules; the pending escape is cleared.
  - Adds a drop counter output drop_count[7:0]: increments (saturating) on each accept in HOLD, clears on reset.
- Without the macro: 8'h7D is ordinary data and the drop_count port does not exist.

Decomposition:
- Package uart_acc_pkg holds:
  - the state enum;
  - error code constants ERR_NONE, ERR_TIMEOUT, ERR_OVERFLOW, ERR_BADTERM;
  - ESC_BYTE=8'h7D and ESC_XOR=8'h20.
- One sub-module, uart_acc_timeout: parametrised cycle counter with clear, enable and expired outputs.

Test Plan:
- ble_side=1; send 41,42,43,0D with frame_ready=1 -> frame_valid one clk after the 0D accept; size=3; output_data[23:0]=24'h434241; done=1; error=0.
- ble_side=0; send 01,BE,EF -> size=1, byte0=01. Then send 01,BE,00 -> error=1, error_code=3, frame_valid stays 0.
- TIMEOUT=20; send one byte then idle 20 clk -> error_code=1, state IDLE. Send 5 with a gap of 19 clk -> no error.
- MAX_BYTES=4; send 5 non-terminator bytes -> error_code=2 on the 5th accept. A 4-byte frame plus terminator succeeds with size=4.
- Hold frame_ready=0 after a frame, send 3 more strobes -> output_data unchanged. With UART_ACC_ESCAPE_EN, drop_count=3.
- UART_ACC_ESCAPE_EN, ble_side=1: send 7D,2D,0D -> size=1, byte0=0D. Also assert reset during ACCUM -> all outputs return to reset values the next clk.
